ball_motion_sequencer: RTL and testbench
========================================

// Module: ball_motion_sequencer
//
// PURPOSE
// Owns position/velocity state for all metaballs and advances it once per frame.
// The update runs in the clk_50mhz domain and replaces per-ball logic clocked on v_sync edges.
// It walks the balls through one shared next-position/velocity datapath.
// Exports fixed-point positions through an index read port that the per-pixel ball evaluators poll.
//
// PARAMETERS
// NUM_BALLS      2    number of balls sequenced (1..8)
// SCREEN_WIDTH   800  visible width, pixels
// SCREEN_HEIGHT  600  visible height, pixels
// BALL_SIZE      128  ball sprite edge, pixels
//
// PORTS
// clk_50mhz  in   1   clock; synchronous, active-high reset
// reset      in   1   synchronous, active-high reset
// v_sync     in   1   raw VGA v_sync (active-low pulse); asynchronous to the update logic
// enable     in   1   1 = frame updates allowed; 0 = freeze motion
// rd_idx     in   3   ball index for the read port
// rd_x       out  10  integer x of ball rd_idx (fix_x[11:2]); combinational read
// rd_y       out  10  integer y of ball rd_idx (fix_y[11:2]); combinational read
// busy       out  1   update sweep in progress
// frame_done out  1   one-cycle pulse: sweep complete
// overrun    out  1   sticky: trigger arrived while busy
//
// BEHAVIOUR
// - State per ball i:
//   - fix_x, fix_y: 12b unsigned, 2 fractional bits.
//   - vx, vy: 10b two's complement.
// - Reset values:
//   - fix_x = ((SCREEN_WIDTH-BALL_SIZE)*(i+1)/(NUM_BALLS+1)) << 2.
//   - fix_y = same formula using SCREEN_HEIGHT.
//   - vx = vy = 0; busy = frame_done = overrun = 0; FSM enters IDLE.
// - Reset mid-sweep aborts the sweep and restores all of the reset values above.
// - v_sync goes through a 2-flop synchroniser, then a rising-edge detector (end of sync pulse).
//   - The detector's first output after reset is 0; an initially-high v_sync is not an edge.
// - Trigger = synced rising edge AND enable.
//   - Trigger while busy: the trigger is dropped and overrun is set to 1 (stays set until reset).
//   - Trigger with enable = 0: ignored; no flag set.
// - FSM states: IDLE -> UPD_X -> UPD_Y -> (idx == NUM_BALLS-1 ? DONE : UPD_X, idx+1) -> IDLE.
//   - A trigger in IDLE sets idx = 0 and moves to UPD_X.
//   - DONE lasts one cycle; frame_done = 1 only in DONE.
//   - busy = 1 in UPD_X and UPD_Y only.
//   - Each UPD state occupies exactly 1 cycle.
// - Datapath, shared by UPD_X and UPD_Y, shown for the x axis:
//   - next = fix_x + sext12(vx), mod 2^12.
//   - Write fix_x <= next.
//   - Write vx <= vx + (next < (HALF_X<<2) ? +1 : -1), mod 2^10.
//   - HALF_X = (SCREEN_WIDTH-BALL_SIZE)/2; HALF_Y is the same using SCREEN_HEIGHT.
// - Latency: raw v_sync rise sampled at edge k:
//   - busy = 1 for edges k+3 .. k+2+2*NUM_BALLS;
//   - frame_done pulses at edge k+3+2*NUM_BALLS.
// - Read port returns committed values.
//   - x updates at the end of UPD_X, before y, so a read mid-sweep may mix frames.
//   - Consumers read outside vertical blanking, so the mix is not visible on screen.
//   - rd_idx >= NUM_BALLS returns 0 on rd_x and rd_y.
// - Position wraps silently mod 2^12; there is no clamping.
//
// TESTING
// 1. Reset, defaults -> rd_idx=0: rd_x=224, rd_y=157; rd_idx=1: rd_x=448, rd_y=314.
//    After reset: busy=0, frame_done=0, overrun=0.
// 2. Three v_sync rises with enable=1 -> ball0 vx: 1, 2, 3; fix_x: 896, 897, 899 (rd_x 224).
//    Ball1 vx: 0x3FF, 0x3FE, 0x3FD.
// 3. One v_sync rise -> busy high exactly 4 cycles starting edge k+3; frame_done single pulse at k+7.
// 4. enable=0 while v_sync toggles for 5 frames -> state unchanged; no busy; overrun stays 0.
// 5. Second synced rise injected during the sweep -> sweep completes normally; overrun=1 until reset.
// 6. Reset asserted at the second UPD cycle -> next cycle IDLE and busy=0; all balls at test-1 values.
//    The next trigger produces the same results as test 2, first frame.

Source files
------------

// File: rtl/ball_motion_sequencer.sv
// Per-frame metaball motion sequencer: one shared position/velocity datapath
// walks every ball once per synchronised v_sync rising edge.
module ball_motion_sequencer #(
    parameter int NUM_BALLS     = 2,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_SIZE     = 128
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       v_sync,
    input  logic       enable,
    input  logic [2:0] rd_idx,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int SPAN_X = SCREEN_WIDTH - BALL_SIZE;
    localparam int SPAN_Y = SCREEN_HEIGHT - BALL_SIZE;
    localparam logic [11:0] MID_X = 12'((SPAN_X / 2) * 4);
    localparam logic [11:0] MID_Y = 12'((SPAN_Y / 2) * 4);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, DONE} state_t;

    state_t state, state_next;

    logic        sync1, sync2, sync_prev, rise;
    logic        trigger;
    logic [2:0]  idx;
    logic        last;

    logic [11:0] fix_x [NUM_BALLS];
    logic [11:0] fix_y [NUM_BALLS];
    logic [9:0]  vx    [NUM_BALLS];
    logic [9:0]  vy    [NUM_BALLS];

    logic [11:0] cur_pos, next_pos, mid;
    logic [9:0]  cur_vel, next_vel;

    // Flops reset high so a v_sync that is already high is not seen as an edge
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            rise      <= 1'b0;
        end else begin
            sync1     <= v_sync;
            sync2     <= sync1;
            sync_prev <= sync2;
            rise      <= sync2 & ~sync_prev;
        end
    end

    assign trigger = rise & enable;
    assign last    = (idx == 3'(NUM_BALLS - 1));

    always_ff @(posedge clk_50mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (trigger) state_next = UPD_X;
            UPD_X: state_next = UPD_Y;
            UPD_Y: state_next = last ? DONE : UPD_X;
            DONE:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == UPD_X) || (state == UPD_Y);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset)                overrun <= 1'b0;
        else if (trigger && busy) overrun <= 1'b1;
    end

    // Shared datapath: axis chosen by state, ball chosen by idx
    always_comb begin
        cur_pos = '0;
        cur_vel = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx == 3'(i)) begin
                cur_pos = (state == UPD_Y) ? fix_y[i] : fix_x[i];
                cur_vel = (state == UPD_Y) ? vy[i] : vx[i];
            end
        end
        mid      = (state == UPD_Y) ? MID_Y : MID_X;
        next_pos = cur_pos + {{2{cur_vel[9]}}, cur_vel};
        next_vel = (next_pos < mid) ? cur_vel + 10'd1 : cur_vel - 10'd1;
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            idx <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                fix_x[i] <= 12'(((SPAN_X * (i + 1)) / (NUM_BALLS + 1)) * 4);
                fix_y[i] <= 12'(((SPAN_Y * (i + 1)) / (NUM_BALLS + 1)) * 4);
                vx[i]    <= '0;
                vy[i]    <= '0;
            end
        end else begin
            if (state == IDLE && trigger)
                idx <= '0;
            else if (state == UPD_Y && !last)
                idx <= idx + 3'd1;
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (idx == 3'(i) && state == UPD_X) begin
                    fix_x[i] <= next_pos;
                    vx[i]    <= next_vel;
                end
                if (idx == 3'(i) && state == UPD_Y) begin
                    fix_y[i] <= next_pos;
                    vy[i]    <= next_vel;
                end
            end
        end
    end

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_x = fix_x[i][11:2];
                rd_y = fix_y[i][11:2];
            end
        end
    end

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Directed bench for ball_motion_sequencer: reset values, motion, latency,
// freeze, overrun and reset mid-sweep.
module tb_ball_motion_sequencer;

    logic       clk_50mhz = 1'b0;
    logic       reset;
    logic       v_sync;
    logic       enable;
    logic [2:0] rd_idx;
    logic [9:0] rd_x, rd_y;
    logic       busy, frame_done, overrun;

    int checks = 0;
    int failures = 0;

    ball_motion_sequencer dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .v_sync    (v_sync),
        .enable    (enable),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic read_ball(input logic [2:0] i, output logic [9:0] x,
                             output logic [9:0] y);
        rd_idx = i;
        #1;
        x = rd_x;
        y = rd_y;
    endtask

    // Low pulse on v_sync, then wait (bounded) for frame_done
    task automatic run_frame(output bit seen);
        seen = 0;
        @(negedge clk_50mhz) v_sync = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        v_sync = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_50mhz);
            #1;
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        @(negedge clk_50mhz);
    endtask

    task automatic test_reset;
        logic [9:0] x, y;
        reset  = 1'b1;
        v_sync = 1'b1;
        enable = 1'b1;
        rd_idx = 3'd0;
        repeat (3) @(posedge clk_50mhz);
        #1;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b ovr=%b want 000",
                     busy, frame_done, overrun);
        end
        @(negedge clk_50mhz) reset = 1'b0;
        read_ball(3'd0, x, y);
        checks++;
        if (x !== 10'd224 || y !== 10'd157) begin
            failures++;
            $display("FAIL reset_ball0 got %0d,%0d want 224,157", x, y);
        end
        read_ball(3'd1, x, y);
        checks++;
        if (x !== 10'd448 || y !== 10'd314) begin
            failures++;
            $display("FAIL reset_ball1 got %0d,%0d want 448,314", x, y);
        end
        read_ball(3'd2, x, y);
        checks++;
        if (x !== 10'd0 || y !== 10'd0) begin
            failures++;
            $display("FAIL rd_idx2_zero got %0d,%0d want 0,0", x, y);
        end
        read_ball(3'd7, x, y);
        checks++;
        if (x !== 10'd0 || y !== 10'd0) begin
            failures++;
            $display("FAIL rd_idx7_zero got %0d,%0d want 0,0", x, y);
        end
    endtask

    task automatic test_motion;
        int ex0[5] = '{224, 224, 224, 225, 226};
        int ey0[5] = '{157, 157, 157, 158, 159};
        int ex1[5] = '{448, 447, 447, 446, 445};
        int ey1[5] = '{314, 313, 313, 312, 311};
        logic [9:0] x, y;
        bit seen;
        for (int f = 0; f < 5; f++) begin
            run_frame(seen);
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL motion_done frame %0d got none want pulse", f);
            end
            read_ball(3'd0, x, y);
            checks++;
            if (x !== 10'(ex0[f]) || y !== 10'(ey0[f])) begin
                failures++;
                $display("FAIL motion_ball0 frame %0d got %0d,%0d want %0d,%0d",
                         f, x, y, ex0[f], ey0[f]);
            end
            read_ball(3'd1, x, y);
            checks++;
            if (x !== 10'(ex1[f]) || y !== 10'(ey1[f])) begin
                failures++;
                $display("FAIL motion_ball1 frame %0d got %0d,%0d want %0d,%0d",
                         f, x, y, ex1[f], ey1[f]);
            end
        end
    endtask

    task automatic test_latency;
        logic eb, ed;
        @(negedge clk_50mhz) v_sync = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        v_sync = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk_50mhz);
            #1;
            eb = (e >= 3 && e <= 6);
            ed = (e == 7);
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL latency_busy edge k+%0d got %b want %b", e, busy, eb);
            end
            checks++;
            if (frame_done !== ed) begin
                failures++;
                $display("FAIL latency_done edge k+%0d got %b want %b",
                         e, frame_done, ed);
            end
        end
        @(negedge clk_50mhz);
    endtask

    task automatic test_freeze;
        logic [9:0] x, y;
        bit saw_busy = 0;
        enable = 1'b0;
        for (int f = 0; f < 5; f++) begin
            @(negedge clk_50mhz) v_sync = 1'b0;
            repeat (3) @(negedge clk_50mhz);
            v_sync = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk_50mhz);
                #1;
                if (busy || frame_done) saw_busy = 1;
            end
        end
        @(negedge clk_50mhz);
        checks++;
        if (saw_busy !== 1'b0) begin
            failures++;
            $display("FAIL freeze_busy got activity want none");
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL freeze_overrun got %b want 0", overrun);
        end
        read_ball(3'd0, x, y);
        checks++;
        if (x !== 10'd227 || y !== 10'd160) begin
            failures++;
            $display("FAIL freeze_ball0 got %0d,%0d want 227,160", x, y);
        end
        read_ball(3'd1, x, y);
        checks++;
        if (x !== 10'd444 || y !== 10'd310) begin
            failures++;
            $display("FAIL freeze_ball1 got %0d,%0d want 444,310", x, y);
        end
        enable = 1'b1;
    endtask

    task automatic test_overrun;
        logic [9:0] x, y;
        bit seen = 0;
        @(negedge clk_50mhz) v_sync = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        v_sync = 1'b1;
        @(negedge clk_50mhz) v_sync = 1'b0;
        @(negedge clk_50mhz) v_sync = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_50mhz);
            #1;
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL overrun_done got none want pulse");
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got %b want 1", overrun);
        end
        repeat (6) @(negedge clk_50mhz);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_sticky got ovr=%b busy=%b want 1,0",
                     overrun, busy);
        end
        read_ball(3'd0, x, y);
        checks++;
        if (x !== 10'd229 || y !== 10'd162) begin
            failures++;
            $display("FAIL overrun_ball0 got %0d,%0d want 229,162", x, y);
        end
        read_ball(3'd1, x, y);
        checks++;
        if (x !== 10'd442 || y !== 10'd308) begin
            failures++;
            $display("FAIL overrun_ball1 got %0d,%0d want 442,308", x, y);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int ex1[2] = '{448, 447};
        int ey1[2] = '{314, 313};
        logic [9:0] x, y;
        bit seen;
        @(negedge clk_50mhz) v_sync = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        v_sync = 1'b1;
        repeat (5) @(posedge clk_50mhz);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midsweep_busy got %b want 1", busy);
        end
        @(negedge clk_50mhz) reset = 1'b1;
        @(posedge clk_50mhz);
        #1;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midsweep_flags busy=%b done=%b ovr=%b want 000",
                     busy, frame_done, overrun);
        end
        read_ball(3'd0, x, y);
        checks++;
        if (x !== 10'd224 || y !== 10'd157) begin
            failures++;
            $display("FAIL midsweep_ball0 got %0d,%0d want 224,157", x, y);
        end
        read_ball(3'd1, x, y);
        checks++;
        if (x !== 10'd448 || y !== 10'd314) begin
            failures++;
            $display("FAIL midsweep_ball1 got %0d,%0d want 448,314", x, y);
        end
        @(negedge clk_50mhz) reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_frame(seen);
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL restart_done frame %0d got none want pulse", f);
            end
            read_ball(3'd0, x, y);
            checks++;
            if (x !== 10'd224 || y !== 10'd157) begin
                failures++;
                $display("FAIL restart_ball0 frame %0d got %0d,%0d want 224,157",
                         f, x, y);
            end
            read_ball(3'd1, x, y);
            checks++;
            if (x !== 10'(ex1[f]) || y !== 10'(ey1[f])) begin
                failures++;
                $display("FAIL restart_ball1 frame %0d got %0d,%0d want %0d,%0d",
                         f, x, y, ex1[f], ey1[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_motion();
        test_latency();
        test_freeze();
        test_overrun();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
